// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector.
// Compares a PAT_W-bit window of a qualified serial stream against a
// runtime-loadable pattern, with overlapping / non-overlapping match modes
// and a saturating match counter with a sticky saturation flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | fewer than PAT_W-1 bits accepted since reset/load/match; no match
// ARMED | PAT_W-1 bits held in history; the next valid bit may complete a match

module seq_detector_param #(
   parameter int               PAT_W       = 4,
   parameter int               CNT_W       = 8,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011
) (
   input  logic             CLK,
   input  logic             RES,
   input  logic             din,
   input  logic             din_valid,
   input  logic             overlap_en,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             clr_count,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat,
   output logic [PAT_W-1:0] pattern
);

   // fill only has to reach PAT_W-1, so clog2(PAT_W) bits always suffice
   // (one bit when PAT_W is 2).
   localparam int               FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t             state;
   logic [PAT_W-2:0]   history;
   logic [FILL_W-1:0]  fill;
   logic [FILL_W-1:0]  fill_nxt;
   logic [PAT_W-1:0]   window;
   logic               hit;

   // Oldest bit lands in the MSB. Taking the low PAT_W-1 bits of the window
   // as the next history avoids a negative slice when PAT_W is 2.
   assign window = {history, din};

   // A completed match on this edge; load always wins over the data bit.
   assign hit = din_valid && !pat_load && (state == ARMED) && (window == pattern);

   // Saturating fill increment used when a valid bit does not match.
   assign fill_nxt = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);

   // Pattern register, history shift, fill tracking and match pulse.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         pattern <= DEFAULT_PAT;
         history <= '0;
         fill    <= '0;
         state   <= FILL;
         match   <= 1'b0;
      end else if (pat_load) begin
         pattern <= pat_in;
         history <= '0;
         fill    <= '0;
         state   <= FILL;
         match   <= 1'b0;
      end else if (din_valid) begin
         history <= window[PAT_W-2:0];
         if (hit) begin
            match <= 1'b1;
            if (overlap_en) begin
               fill  <= FILL_MAX;
               state <= ARMED;
            end else begin
               // Non-overlapping: a completely fresh window is required.
               fill  <= '0;
               state <= FILL;
            end
         end else begin
            match <= 1'b0;
            fill  <= fill_nxt;
            state <= (fill_nxt == FILL_MAX) ? ARMED : FILL;
         end
      end else begin
         match <= 1'b0;
      end
   end

   // Saturating match counter; a clear beats a same-edge increment.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         match_count <= '0;
         count_sat   <= 1'b0;
      end else if (clr_count) begin
         match_count <= '0;
         count_sat   <= 1'b0;
      end else if (hit) begin
         if (match_count == CNT_MAX) begin
            count_sat <= 1'b1;
         end else begin
            match_count <= match_count + CNT_W'(1);
         end
      end
   end

endmodule
